regfile_scoreboard: RTL

- General-purpose register file: 32 x 32-bit, r0 hardwired to zero.
- It is the receiving end of the writeback stage's register write port (`reg_idx`, `reg_we`, `reg_data`).
- Serves two combinational read ports to decode/issue.
- Keeps a per-register in-flight write counter (scoreboard) so issue can detect RAW hazards and stall.

---
 rtl/regfile_scoreboard.sv | 93 +++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// 32x32 register file (r0 = 0) with two combinational read ports and per-register in-flight write counters for RAW stalls.
// Reads are zero latency; issue stalls via issue_ready when a counter saturates. `REGFILE_WB_BYPASS_EN` forwards same-cycle writeback.
module regfile_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  localparam int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] reg_idx,
  input  logic          reg_we,
  input  logic [31:0]   reg_data,
  input  logic [IW-1:0] rj_idx,
  input  logic [IW-1:0] rk_idx,
  output logic [31:0]   rj_data,
  output logic [31:0]   rk_data,
  output logic          rj_busy,
  output logic          rk_busy,
  input  logic          issue_valid,
  input  logic          issue_wr,
  input  logic [IW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic          flush_i
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      regs [NREG];
  logic [CNT_W-1:0] cnt  [NREG];
  logic [NREG-1:0]  inc_v;
  logic [NREG-1:0]  dec_v;
  logic [31:0]      rj_reg;
  logic [31:0]      rk_reg;
  logic             rj_cnt_nz;
  logic             rk_cnt_nz;

  // Ready looks only at the registered count; a same-cycle writeback is not credited.
  assign issue_ready = (cnt[issue_rd] != CNT_MAX) | ~issue_wr | (issue_rd == '0);

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 1; i < NREG; i++) begin
      inc_v[i] = issue_valid & issue_wr & issue_ready & (issue_rd == IW'(i));
      dec_v[i] = reg_we & (reg_idx == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (reg_we && reg_idx != '0)
        regs[reg_idx] <= reg_data;
      for (int i = 0; i < NREG; i++) begin
        // Flush empties the pipe, so no writebacks remain outstanding; a later stray one saturates at 0.
        if (flush_i)
          cnt[i] <= '0;
        else if (inc_v[i] && !dec_v[i])
          cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec_v[i] && !inc_v[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  assign rj_reg    = (rj_idx == '0) ? 32'd0 : regs[rj_idx];
  assign rk_reg    = (rk_idx == '0) ? 32'd0 : regs[rk_idx];
  assign rj_cnt_nz = (rj_idx != '0) && (cnt[rj_idx] != '0);
  assign rk_cnt_nz = (rk_idx != '0) && (cnt[rk_idx] != '0);

`ifdef REGFILE_WB_BYPASS_EN
  logic rj_fwd;
  logic rk_fwd;

  assign rj_fwd  = reg_we && (reg_idx == rj_idx) && (rj_idx != '0);
  assign rk_fwd  = reg_we && (reg_idx == rk_idx) && (rk_idx != '0);
  assign rj_data = rj_fwd ? reg_data : rj_reg;
  assign rk_data = rk_fwd ? reg_data : rk_reg;
  assign rj_busy = rj_fwd ? (cnt[rj_idx] > CNT_ONE) : rj_cnt_nz;
  assign rk_busy = rk_fwd ? (cnt[rk_idx] > CNT_ONE) : rk_cnt_nz;
`else
  assign rj_data = rj_reg;
  assign rk_data = rk_reg;
  assign rj_busy = rj_cnt_nz;
  assign rk_busy = rk_cnt_nz;
`endif

endmodule
